// File: rtl/safe_wrapper_csr.sv
// Register bus types shared by the wrapper CSR mux and its leaf register files.
package reg_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;

endpackage

// safe_wrapper_csr: redundancy-mode / master-core CSRs plus the halt-all /
// resume-all lockstep resynchronisation sequencer for NHARTS cores.
module safe_wrapper_csr #(
    parameter int NHARTS         = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  reg_pkg::reg_req_t   reg_req_i,
    output reg_pkg::reg_rsp_t   reg_rsp_o,
    output logic [1:0]          safe_mode_o,
    output logic [1:0]          master_core_o,
    output logic [NHARTS-1:0]   halt_req_o,
    input  logic [NHARTS-1:0]   core_halted_i,
    output logic [NHARTS-1:0]   resume_o,
    output logic                sync_done_irq_o
);

    localparam int              CW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]     NHARTS_U = 32'(NHARTS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_HALT,
        ST_RESUME
    } state_t;

    state_t         state_reg, state_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic [1:0]     mode_reg, mode_next;
    logic [1:0]     master_reg, master_next;
    logic           done_reg, done_next;
    logic           timeout_reg, timeout_next;
    logic [15:0]    sync_count_reg, sync_count_next;

    // Bus decode results
    logic [2:0]     reg_idx;
    logic           misaligned;
    logic [1:0]     wr_val;
    logic           busy;
    logic           all_halted;
    logic [31:0]    rsp_rdata;
    logic           rsp_error;
    logic           mode_we, master_we, start_req, clr_timeout, clr_done;
    logic           set_done, set_timeout;
    logic           unused_bits;

    assign reg_idx    = reg_req_i.addr[4:2];
    assign misaligned = |reg_req_i.addr[1:0];
    assign wr_val     = reg_req_i.wdata[1:0];
    assign busy       = (state_reg != ST_IDLE);
    assign all_halted = &core_halted_i;

    // Only addr[4:0], wdata[2:0] and wstrb[0] carry meaning here.
    assign unused_bits = ^{reg_req_i.addr[31:5], reg_req_i.wdata[31:3], reg_req_i.wstrb[3:1]};

    // Combinational register access: response data/error and write strobes.
    always_comb begin
        rsp_rdata   = 32'd0;
        rsp_error   = 1'b0;
        mode_we     = 1'b0;
        master_we   = 1'b0;
        start_req   = 1'b0;
        clr_timeout = 1'b0;
        clr_done    = 1'b0;
        if (reg_req_i.valid) begin
            if (misaligned || (reg_idx > 3'd4)) begin
                rsp_error = 1'b1;
            end else if (reg_req_i.write) begin
                if (reg_req_i.wstrb[0]) begin
                    case (reg_idx)
                        3'd0: begin
                            if (busy || (wr_val == 2'd3)) rsp_error = 1'b1;
                            else                          mode_we   = 1'b1;
                        end
                        3'd1: begin
                            if (busy || ({30'd0, wr_val} >= NHARTS_U)) rsp_error = 1'b1;
                            else                                       master_we = 1'b1;
                        end
                        3'd2: begin
                            if (busy) rsp_error = 1'b1;
                            else      start_req = reg_req_i.wdata[0];
                        end
                        3'd3: begin
                            clr_timeout = reg_req_i.wdata[1];
                            clr_done    = reg_req_i.wdata[2];
                        end
                        default: ;
                    endcase
                end
            end else begin
                case (reg_idx)
                    3'd0:    rsp_rdata = {30'd0, mode_reg};
                    3'd1:    rsp_rdata = {30'd0, master_reg};
                    3'd3:    rsp_rdata = {29'd0, done_reg, timeout_reg, busy};
                    3'd4:    rsp_rdata = {16'd0, sync_count_reg};
                    default: rsp_rdata = 32'd0;
                endcase
            end
        end
    end

    assign reg_rsp_o = '{rdata: rsp_rdata, error: rsp_error, ready: 1'b1};

    // Sync sequencer next state, timeout counter and status/count updates.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        set_done    = 1'b0;
        set_timeout = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start_req) begin
                    state_next = ST_WAIT_HALT;
                    cnt_next   = '0;
                end
            end
            ST_WAIT_HALT: begin
                cnt_next = cnt_reg + 1'b1;
                // A halt arriving on the last allowed cycle still counts as success.
                if (all_halted) begin
                    state_next = ST_RESUME;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next  = ST_IDLE;
                    set_timeout = 1'b1;
                end
            end
            ST_RESUME: begin
                state_next = ST_IDLE;
                set_done   = 1'b1;
            end
            default: state_next = ST_IDLE;
        endcase

        mode_next       = mode_we   ? wr_val : mode_reg;
        master_next     = master_we ? wr_val : master_reg;
        // Hardware set beats a same-cycle software clear.
        done_next       = (done_reg    & ~clr_done)    | set_done;
        timeout_next    = (timeout_reg & ~clr_timeout) | set_timeout;
        sync_count_next = sync_count_reg + {15'd0, set_done};
    end

    // State and register storage with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            mode_reg       <= 2'd0;
            master_reg     <= 2'd0;
            done_reg       <= 1'b0;
            timeout_reg    <= 1'b0;
            sync_count_reg <= 16'd0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            mode_reg       <= mode_next;
            master_reg     <= master_next;
            done_reg       <= done_next;
            timeout_reg    <= timeout_next;
            if (set_done) begin
                sync_count_reg <= sync_count_next;
            end
        end
    end

    assign safe_mode_o     = mode_reg;
    assign master_core_o   = master_reg;
    assign halt_req_o      = {NHARTS{state_reg == ST_WAIT_HALT}};
    assign resume_o        = {NHARTS{state_reg == ST_RESUME}};
    assign sync_done_irq_o = (state_reg == ST_RESUME);

endmodule

// File: tb/tb_safe_wrapper_csr.sv
// Self-checking bench for safe_wrapper_csr: directed register and sync
// scenarios plus randomized register traffic and sync latencies, checked
// against a register-level reference model kept in the bench.
module tb_safe_wrapper_csr;
    import reg_pkg::*;

    localparam int NH = 3;
    localparam int TO = 8;
    localparam logic [NH-1:0] ALL1 = {NH{1'b1}};

    logic            clk = 1'b0;
    logic            rst;
    reg_req_t        req;
    reg_rsp_t        rsp;
    logic [1:0]      safe_mode, master_core;
    logic [NH-1:0]   halt_req, core_halted, resume;
    logic            irq;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: architectural register contents
    logic [1:0]  m_mode, m_master;
    logic        m_done, m_timeout;
    logic [15:0] m_count;

    safe_wrapper_csr #(.NHARTS(NH), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .reg_req_i       (req),
        .reg_rsp_o       (rsp),
        .safe_mode_o     (safe_mode),
        .master_core_o   (master_core),
        .halt_req_o      (halt_req),
        .core_halted_i   (core_halted),
        .resume_o        (resume),
        .sync_done_irq_o (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 2'd0; m_master = 2'd0; m_done = 1'b0; m_timeout = 1'b0; m_count = 16'd0;
    endtask

    // Expected response and side effects of one access, from the register map rules.
    task automatic model_access(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                                input logic [3:0] strb, input logic busy,
                                output logic e_err, output logic [31:0] e_rdata, output logic start);
        int idx;
        idx = int'(addr[4:2]);
        e_err = 1'b0; e_rdata = 32'd0; start = 1'b0;
        if (addr[1:0] != 2'd0 || idx > 4) begin
            e_err = 1'b1;
        end else if (!wr) begin
            case (idx)
                0: e_rdata = 32'(m_mode);
                1: e_rdata = 32'(m_master);
                3: e_rdata = 32'(m_done) * 4 + 32'(m_timeout) * 2 + 32'(busy);
                4: e_rdata = 32'(m_count);
                default: e_rdata = 32'd0;
            endcase
        end else if (strb[0]) begin
            case (idx)
                0: if (busy || wdata[1:0] == 2'd3) e_err = 1'b1; else m_mode = wdata[1:0];
                1: if (busy || int'(wdata[1:0]) >= NH) e_err = 1'b1; else m_master = wdata[1:0];
                2: if (busy) e_err = 1'b1; else start = wdata[0];
                3: begin
                    if (wdata[1]) m_timeout = 1'b0;
                    if (wdata[2]) m_done = 1'b0;
                end
                default: ;
            endcase
        end
    endtask

    // One bus cycle starting at posedge+1; returns at posedge+1 of the next cycle.
    task automatic bus_op(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                          input logic [3:0] strb, output logic err, output logic [31:0] rdata);
        req.addr = addr; req.write = wr; req.wdata = wdata; req.wstrb = strb; req.valid = 1'b1;
        #1;
        err = rsp.error; rdata = rsp.rdata;
        check("ready", 32'(rsp.ready), 32'd1);
        @(posedge clk); #1;
        req.valid = 1'b0; req.write = 1'b0;
    endtask

    task automatic access(input string tag, input logic [31:0] addr, input logic wr,
                          input logic [31:0] wdata, input logic [3:0] strb, input logic busy);
        logic e_err, err, st;
        logic [31:0] e_rd, rd;
        model_access(addr, wr, wdata, strb, busy, e_err, e_rd, st);
        bus_op(addr, wr, wdata, strb, err, rd);
        $display("%s addr=%08h wr=%0d wdata=%08h strb=%h -> err=%0d rdata=%08h",
                 tag, addr, wr, wdata, strb, err, rd);
        check({tag, "_err"}, 32'(err), 32'(e_err));
        if (!wr || e_err) check({tag, "_rdata"}, rd, e_rd);
    endtask

    // k = cycle offset after the start write at which all cores report halted; 0 = never.
    task automatic run_sync(input int k, input bit busy_probe, input bit w1c_probe);
        logic e_err, err, st;
        logic [31:0] e_rd, rd;
        int last, hits;
        logic exp_halt, exp_res;
        int unsigned tmp;
        model_access(32'h08, 1'b1, 32'h1, 4'h1, 1'b0, e_err, e_rd, st);
        bus_op(32'h08, 1'b1, 32'h1, 4'h1, err, rd);
        check("sync_start_err", 32'(err), 32'(e_err));
        last = (k == 0) ? TO + 2 : k + 2;
        hits = 0;
        for (int i = 1; i <= last; i++) begin
            exp_halt = (k == 0) ? (i <= TO) : (i <= k);
            exp_res  = (k != 0) && (i == k + 1);
            if (k != 0 && i >= k && i <= k + 1) begin
                core_halted = ALL1;
            end else begin
                tmp = $urandom_range(0, 6);
                core_halted = NH'(tmp);
            end
            check("halt_req", 32'(halt_req), exp_halt ? 32'(ALL1) : 32'd0);
            check("resume",   32'(resume),   exp_res  ? 32'(ALL1) : 32'd0);
            check("irq",      32'(irq),      32'(exp_res));
            if (busy_probe && i == 1) begin
                access("busy_mode_wr", 32'h00, 1'b1, 32'((int'(m_mode) + 1) % 3), 4'h1, 1'b1);
            end else if (busy_probe && i == 2 && (k == 0 || i <= k)) begin
                access("busy_restart", 32'h08, 1'b1, 32'h1, 4'h1, 1'b1);
            end else if (w1c_probe && k != 0 && i == k + 1) begin
                access("w1c_done_resume", 32'h0C, 1'b1, 32'h4, 4'h1, 1'b1);
            end else if (w1c_probe && k == 0 && i == TO) begin
                access("w1c_timeout_edge", 32'h0C, 1'b1, 32'h2, 4'h1, 1'b1);
            end else begin
                @(posedge clk); #1;
            end
            if (k != 0 && i == k + 1) begin m_done = 1'b1; m_count = m_count + 16'd1; end
            if (k == 0 && i == TO) m_timeout = 1'b1;
        end
        core_halted = '0;
        $display("sync k=%0d busy_probe=%0d w1c_probe=%0d complete", k, busy_probe, w1c_probe);
        access("status_after", 32'h0C, 1'b0, 32'h0, 4'h0, 1'b0);
        access("count_after",  32'h10, 1'b0, 32'h0, 4'h0, 1'b0);
        check("mode_out_after_sync", 32'(safe_mode), 32'(m_mode));
    endtask

    initial begin
        int unsigned tmp;
        int idx;
        logic [31:0] addr, wdata;
        logic wr;
        logic [3:0] strb;

        req = '0;
        core_halted = '0;
        rst = 1'b1;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        check("rst_mode",   32'(safe_mode),   32'd0);
        check("rst_master", 32'(master_core), 32'd0);
        check("rst_halt",   32'(halt_req),    32'd0);
        check("rst_resume", 32'(resume),      32'd0);
        check("rst_irq",    32'(irq),         32'd0);
        check("rst_rsp",    32'(rsp),         32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int a = 0; a <= 16; a += 4) access("rst_read", 32'(a), 1'b0, 32'h0, 4'h0, 1'b0);

        access("wr_mode2",   32'h00, 1'b1, 32'h2, 4'h1, 1'b0);
        access("wr_master1", 32'h04, 1'b1, 32'h1, 4'h1, 1'b0);
        access("rd_mode",    32'h00, 1'b0, 32'h0, 4'h0, 1'b0);
        access("rd_master",  32'h04, 1'b0, 32'h0, 4'h0, 1'b0);
        access("wr_mode3",   32'h00, 1'b1, 32'h3, 4'h1, 1'b0);
        access("wr_master3", 32'h04, 1'b1, 32'h3, 4'h1, 1'b0);
        access("rd_mode",    32'h00, 1'b0, 32'h0, 4'h0, 1'b0);
        access("rd_master",  32'h04, 1'b0, 32'h0, 4'h0, 1'b0);
        access("wr_nostrb",  32'h00, 1'b1, 32'h1, 4'hE, 1'b0);
        access("wr_ro_cnt",  32'h10, 1'b1, 32'h55, 4'hF, 1'b0);
        access("rd_unmap",   32'h18, 1'b0, 32'h0, 4'h0, 1'b0);
        access("rd_misal",   32'h01, 1'b0, 32'h0, 4'h0, 1'b0);
        access("rd_upper",   32'hABCD_0004, 1'b0, 32'h0, 4'h0, 1'b0);
        check("mode_out",   32'(safe_mode),   32'd2);
        check("master_out", 32'(master_core), 32'd1);

        run_sync(3, 1'b0, 1'b0);
        access("clr_done", 32'h0C, 1'b1, 32'h4, 4'h1, 1'b0);
        run_sync(0, 1'b1, 1'b0);
        access("clr_timeout", 32'h0C, 1'b1, 32'h2, 4'h1, 1'b0);
        access("rd_status",   32'h0C, 1'b0, 32'h0, 4'h0, 1'b0);
        run_sync(0, 1'b0, 1'b1);
        run_sync(TO, 1'b1, 1'b0);

        for (int n = 0; n < 40; n++) begin
            idx = int'($urandom_range(0, 7));
            tmp = $urandom();
            addr = {tmp[31:5], 3'(idx), 2'b00};
            if ($urandom_range(0, 7) == 0) addr[1:0] = 2'($urandom_range(1, 3));
            wr = 1'($urandom_range(0, 1));
            wdata = $urandom();
            if (addr[4:2] == 3'd2) wdata[0] = 1'b0;
            strb = 4'($urandom_range(0, 15));
            access("rand", addr, wr, wdata, strb, 1'b0);
            check("rand_mode_out",   32'(safe_mode),   32'(m_mode));
            check("rand_master_out", 32'(master_core), 32'(m_master));
        end

        for (int n = 0; n < 6; n++) begin
            run_sync(int'($urandom_range(1, TO)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        run_sync(0, 1'b1, 1'b1);

        force dut.sync_count_reg = 16'hFFFF;
        #1;
        release dut.sync_count_reg;
        @(posedge clk); #1;
        m_count = 16'hFFFF;
        access("rd_preload", 32'h10, 1'b0, 32'h0, 4'h0, 1'b0);
        run_sync(1, 1'b0, 1'b1);

        begin
            logic e_err, err, st;
            logic [31:0] e_rd, rd;
            model_access(32'h08, 1'b1, 32'h1, 4'h1, 1'b0, e_err, e_rd, st);
            bus_op(32'h08, 1'b1, 32'h1, 4'h1, err, rd);
            check("pre_rst_halt", 32'(halt_req), 32'(ALL1));
            @(posedge clk); #1;
            rst = 1'b1;
            #1;
            check("async_rst_halt", 32'(halt_req),  32'd0);
            check("async_rst_mode", 32'(safe_mode), 32'd0);
            check("async_rst_irq",  32'(irq),       32'd0);
            model_reset();
            @(posedge clk); #1;
            rst = 1'b0;
            @(posedge clk); #1;
            for (int a = 0; a <= 16; a += 4) access("post_rst_read", 32'(a), 1'b0, 32'h0, 4'h0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/safe_wrapper_csr.md
# safe_wrapper_csr

Control/status register file and core-synchronisation sequencer for the safe-CPU wrapper. It sits directly downstream of the wrapper CSR register mux and terminates its `reg_req_t`/`reg_rsp_t` port. It holds the redundancy mode (single/DMR/TMR) and the master-core selection. It also runs a halt-all/resume-all handshake with the NHARTS cores when software requests a lockstep resynchronisation.

## Interface
Parameters:
- `NHARTS`, 3: number of cores under control (1..4).
- `TIMEOUT_CYCLES`, 1024: maximum cycles spent waiting for all cores to halt (≥2).

Ports:
- `clk_i`  in  1  system clock.
- `rst_i`  in  1  reset; one clock; reset is asynchronous and active-high.
- `reg_req_i`  in  `reg_pkg::reg_req_t`  register request (addr[31:0], write, wdata[31:0], wstrb[3:0], valid).
- `reg_rsp_o`  out  `reg_pkg::reg_rsp_t`  register response (rdata[31:0], error, ready).
- `safe_mode_o`  out  2  0 = single, 1 = DMR, 2 = TMR.
- `master_core_o`  out  2  index of the master core.
- `halt_req_o`  out  NHARTS  halt request, one bit per core.
- `core_halted_i`  in  NHARTS  per-core halted acknowledge, level.
- `resume_o`  out  NHARTS  one-cycle resume pulse per core.
- `sync_done_irq_o`  out  1  one-cycle pulse when a synchronisation completes.

## Operation
- Decode uses `addr[4:0]`. Upper address bits are ignored.
- `addr[1:0] != 0` gives `error=1`, with no side effect.
- Register map:
  - 0x00 SAFE_MODE [1:0], RW. Reset value 0.
  - 0x04 MASTER_CORE [1:0], RW. Reset value 0.
  - 0x08 SYNC_START, WO. A write with wdata[0]=1 starts a sync. Reads return 0.
  - 0x0C STATUS, R/W1C:
    - [0] busy, read-only.
    - [1] timeout, sticky, W1C.
    - [2] done, sticky, W1C.
  - 0x10 SYNC_COUNT [15:0], RO. Counts completed syncs and wraps 0xFFFF→0.
  - 0x14–0x1C: unmapped, `error=1`.
- Write byte enables:
  - wstrb[0] gates all writable fields, since every field is in byte 0.
  - A write with wstrb[0]=0 is accepted with no effect.
- Illegal writes give `error=1` and leave the register unchanged:
  - SAFE_MODE write of 3.
  - MASTER_CORE write ≥ NHARTS.
  - Any write to SAFE_MODE, MASTER_CORE or SYNC_START while busy.
- Writes to RO registers are ignored with `error=0`.
- Sync FSM states: IDLE, WAIT_HALT, RESUME.
  - IDLE → WAIT_HALT on an accepted SYNC_START write. This clears the timeout counter.
  - In WAIT_HALT: `halt_req_o` = all ones, busy=1, and the counter increments every cycle.
  - WAIT_HALT → RESUME when `core_halted_i` is all ones.
  - WAIT_HALT → IDLE when the counter equals TIMEOUT_CYCLES-1 and the cores are not all halted. This sets timeout, drops `halt_req_o` and issues no resume.
  - If all cores are halted in the same cycle the timeout is reached, the halt wins and the FSM goes to RESUME.
  - RESUME lasts exactly one cycle and then returns to IDLE. During it:
    - `halt_req_o`=0 and `resume_o` = all ones.
    - `sync_done_irq_o`=1.
    - done is set and SYNC_COUNT increments.
- Set/clear collisions: if a W1C clear hits done or timeout in the same cycle the hardware sets that bit, the set wins.
- Arithmetic:
  - The counter is `$clog2(TIMEOUT_CYCLES)` bits wide.
  - SYNC_COUNT is 16 bits with modular increment.

## Timing
- Reset state, applied asynchronously and immediately:
  - FSM in IDLE and all registers 0.
  - `safe_mode_o`=0, `master_core_o`=0, `halt_req_o`=0, `resume_o`=0, `sync_done_irq_o`=0.
  - `reg_rsp_o` = {rdata 0, error 0, ready 1}.
- Reset asserted in WAIT_HALT or RESUME drops `halt_req_o` and `resume_o` in the same cycle.
- Register responses are combinational: `ready`=1 always, and `rdata`/`error` are valid in the same cycle as `valid`. `rdata`=0 when `error`=1.
- Write effects are registered and visible on outputs and reads from the cycle after the request.
- Sync start:
  - A SYNC_START write in cycle T gives `halt_req_o` = all ones from T+1.
  - If `core_halted_i` is all ones during cycle T+k, RESUME is in T+k+1 and IDLE in T+k+2.
  - The fastest sync (k=1) therefore has its resume pulse at T+2.
- Timeout: if the cores never halt, `halt_req_o` is high for exactly TIMEOUT_CYCLES cycles, T+1..T+TIMEOUT_CYCLES. timeout is readable from T+TIMEOUT_CYCLES+1.
- `core_halted_i` is assumed synchronous to `clk_i`. No synchroniser is required.

## Test plan
- Reset, then read every register → all read 0, STATUS=0, all outputs 0, `ready`=1.
- Write SAFE_MODE=2 and MASTER_CORE=1 → both read back. Write SAFE_MODE=3 → `error`=1, reads 2. Write MASTER_CORE=3 (NHARTS=3) → `error`=1, reads 1.
- SYNC_START at T, `core_halted_i`=3'b111 from T+3:
  - `halt_req_o`=3'b111 over T+1..T+3.
  - `resume_o`=3'b111 and `irq`=1 only at T+4.
  - STATUS=0x4 and SYNC_COUNT=1 afterwards.
- TIMEOUT_CYCLES=8 with one core never halting:
  - `halt_req_o` high T+1..T+8, no `resume_o`.
  - STATUS=0x2. Writing STATUS=0x2 clears it to 0.
- While busy:
  - Write SAFE_MODE=1 → `error`=1, mode unchanged.
  - A second SYNC_START → `error`=1, no restart.
- Preload SYNC_COUNT=0xFFFF through 65535 syncs (backdoor allowed), then one sync → SYNC_COUNT=0. A W1C of done in the RESUME cycle leaves done=1.
